// File: rtl/dual_seven_seg_decoder.sv
// Recovers a 0-15 value from a two-digit active-low seven-segment pattern, with
// stability filtering, dedupe and valid/ready output. Macro SEG_DECODE_ERROR_COUNT_EN adds err_count.
module dual_seven_seg_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [13:0]      seg_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [3:0]       out_value,
    output logic             out_err,
    output logic             overrun
`ifdef SEG_DECODE_ERROR_COUNT_EN
    ,
    output logic [CNT_W-1:0] err_count
`endif
);

    localparam logic [13:0] BLANK = 14'h3FFF;
    localparam logic [6:0]  TENS_BLANK = 7'b1111111;
    localparam logic [6:0]  TENS_ONE   = 7'b1001111;

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || CNT_W < 1) begin : g_param_check
        $error("dual_seven_seg_decoder: parameter out of range");
    end

    typedef enum logic {SETTLE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [13:0] seg_q, seg_prev, last_pat;
    logic [7:0]  stab_cnt, stab_cnt_nxt;
    logic        changed, settled, new_res;
    logic [8:0]  samples;
    logic [3:0]  unit_idx;
    logic        dec_legal;
    logic [3:0]  dec_value;

    // The sample where seg_q changes is the first sample of the new value.
    assign changed = (seg_q != seg_prev);
    assign samples = changed ? 9'd1 : {1'b0, stab_cnt} + 9'd2;
    assign settled = (state == SETTLE) && (samples >= 9'(STABLE_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SETTLE;
            stab_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            stab_cnt <= stab_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        stab_cnt_nxt = stab_cnt;
        case (state)
            SETTLE: begin
                if (settled) begin
                    state_nxt    = HOLD;
                    stab_cnt_nxt = 8'd0;
                end else begin
                    stab_cnt_nxt = changed ? 8'd0 : stab_cnt + 8'd1;
                end
            end
            HOLD: begin
                if (changed) begin
                    state_nxt    = SETTLE;
                    stab_cnt_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt    = SETTLE;
                stab_cnt_nxt = 8'd0;
            end
        endcase
    end

    always_comb begin
        new_res = settled && (seg_q != last_pat) && (seg_q != BLANK);
    end

    always_comb begin
        unit_idx = 4'hF;
        case (seg_q[6:0])
            7'b0000001: unit_idx = 4'd0;
            7'b1001111: unit_idx = 4'd1;
            7'b0010010: unit_idx = 4'd2;
            7'b0000110: unit_idx = 4'd3;
            7'b1001100: unit_idx = 4'd4;
            7'b0100100: unit_idx = 4'd5;
            7'b0100000: unit_idx = 4'd6;
            7'b0001111: unit_idx = 4'd7;
            7'b0000000: unit_idx = 4'd8;
            7'b0000100: unit_idx = 4'd9;
            default:    unit_idx = 4'hF;
        endcase
        dec_legal = 1'b0;
        dec_value = 4'd0;
        if (seg_q[13:7] == TENS_BLANK && unit_idx <= 4'd9) begin
            dec_legal = 1'b1;
            dec_value = unit_idx;
        end else if (seg_q[13:7] == TENS_ONE && unit_idx <= 4'd5) begin
            dec_legal = 1'b1;
            dec_value = unit_idx + 4'd10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= BLANK;
            seg_prev  <= BLANK;
            last_pat  <= BLANK;
            out_valid <= 1'b0;
            out_value <= 4'd0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            seg_q    <= seg_in;
            seg_prev <= seg_q;
            if (new_res)
                last_pat <= seg_q;
            // A transfer on the same edge frees the holding register for the new result.
            if (new_res && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_value <= dec_legal ? dec_value : 4'd0;
                out_err   <= ~dec_legal;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (new_res && out_valid && !out_ready)
                overrun <= 1'b1;
        end
    end

`ifdef SEG_DECODE_ERROR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (new_res && !dec_legal && err_count != {CNT_W{1'b1}})
            err_count <= err_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_dual_seven_seg_decoder.sv
// Directed and randomized checks of dual_seven_seg_decoder against a table-driven
// decode model and a latency/dedupe event model.
module tb_dual_seven_seg_decoder;

    localparam int STABLE = 4;
    localparam int CW     = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [13:0]   seg_in;
    logic          out_ready;
    logic          out_valid;
    logic [3:0]    out_value;
    logic          out_err;
    logic          overrun;
`ifdef SEG_DECODE_ERROR_COUNT_EN
    logic [CW-1:0] err_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [6:0]  digit [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    bit          exp_v   [1024];
    logic [3:0]  exp_val [1024];
    bit          exp_err [1024];
    logic [13:0] pat_at  [1024];

    dual_seven_seg_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .out_ready(out_ready),
        .out_valid(out_valid), .out_value(out_value), .out_err(out_err), .overrun(overrun)
`ifdef SEG_DECODE_ERROR_COUNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] code_of(input int v);
        return {(v >= 10) ? 7'b1001111 : 7'b1111111, digit[v % 10]};
    endfunction

    // {legal, value}
    function automatic logic [4:0] ref_dec(input logic [13:0] p);
        for (int d = 0; d < 10; d++) begin
            if (p[6:0] == digit[d]) begin
                if (p[13:7] == 7'b1111111) return {1'b1, 4'(d)};
                if (p[13:7] == 7'b1001111 && d <= 5) return {1'b1, 4'(d + 10)};
            end
        end
        return 5'd0;
    endfunction

    task automatic hold(input logic [13:0] p, input int n, output int nres,
                        output logic [3:0] v, output logic e);
        nres = 0; v = 4'd0; e = 1'b0;
        seg_in = p;
        for (int k = 0; k < n; k++) begin
            tick();
            if (out_valid === 1'b1) begin
                nres++; v = out_value; e = out_err;
            end
        end
    endtask

    initial begin
        int n;
        logic [3:0] v;
        logic e;
        logic [13:0] pat_q [$];
        int len_q [$];
        logic [13:0] prev, last;
        int t;

        reset = 1'b1; seg_in = 14'h3FFF; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_value", 32'(out_value), 32'd0);
        check("reset_err",   32'(out_err),   32'd0);
        check("reset_ovr",   32'(overrun),   32'd0);
`ifdef SEG_DECODE_ERROR_COUNT_EN
        check("reset_cnt", 32'(err_count), 32'd0);
`endif
        for (int k = 0; k < 6; k++) tick();

        // 1: latency and single-cycle pulse
        seg_in = 14'b11111110000110;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t1_valid_c%0d", k), 32'(out_valid), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check("t1_value", 32'(out_value), 32'd3);
                check("t1_err",   32'(out_err),   32'd0);
            end
        end

        // 2: backpressure holds the result until the first ready edge
        out_ready = 1'b0;
        seg_in = 14'b10011110100100;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check($sformatf("t2_valid_c%0d", k), 32'(out_valid), (k >= 5) ? 32'd1 : 32'd0);
            if (k >= 5) check("t2_value", 32'(out_value), 32'd15);
        end
        out_ready = 1'b1;
        tick();
        check("t2_after_xfer", 32'(out_valid), 32'd0);

        // 3: glitch back to the last reported code is silent
        hold(code_of(0), 6, n, v, e);
        check("t3_zero_n", n, 1);
        check("t3_zero_v", 32'(v), 32'd0);
        hold(code_of(8), 2, n, v, e);
        check("t3_glitch_n", n, 0);
        hold(code_of(0), 8, n, v, e);
        check("t3_return_n", n, 0);
        hold(code_of(8), 6, n, v, e);
        check("t3_eight_n", n, 1);
        check("t3_eight_v", 32'(v), 32'd8);

        // 4: illegal pattern and blank
        hold(14'b10011110000000, 6, n, v, e);
        check("t4_ill_n", n, 1);
        check("t4_ill_err", 32'(e), 32'd1);
        check("t4_ill_v", 32'(v), 32'd0);
`ifdef SEG_DECODE_ERROR_COUNT_EN
        check("t4_cnt1", 32'(err_count), 32'd1);
`endif
        hold(14'h3FFF, 6, n, v, e);
        check("t4_blank_n", n, 0);
`ifdef SEG_DECODE_ERROR_COUNT_EN
        check("t4_cnt_blank", 32'(err_count), 32'd1);
`endif

        // 5: overrun, then reset clears it
        out_ready = 1'b0;
        hold(code_of(5), 6, n, v, e);
        check("t5_first_v", 32'(out_value), 32'd5);
        check("t5_first_ovr", 32'(overrun), 32'd0);
        hold(code_of(7), 6, n, v, e);
        check("t5_keep_valid", 32'(out_valid), 32'd1);
        check("t5_keep_v", 32'(out_value), 32'd5);
        check("t5_ovr", 32'(overrun), 32'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_ovr", 32'(overrun), 32'd0);
        check("t5_rst_value", 32'(out_value), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        // 6: sweep all legal codes
        for (int i = 0; i < 16; i++) begin
            hold(code_of(i), 6, n, v, e);
            check($sformatf("t6_n_%0d", i), n, 1);
            check($sformatf("t6_v_%0d", i), 32'(v), 32'(i));
            check($sformatf("t6_e_%0d", i), 32'(e), 32'd0);
        end
        check("t6_ovr", 32'(overrun), 32'd0);

        // Random segments of random length, ready held high
        prev = code_of(15);
        for (int s = 0; s < 60; s++) begin
            logic [13:0] p;
            do begin
                case ($urandom_range(0, 3))
                    0, 1:    p = code_of(int'($urandom_range(0, 15)));
                    2:       p = 14'h3FFF;
                    default: p = 14'($urandom);
                endcase
            end while (p == prev);
            pat_q.push_back(p);
            len_q.push_back(int'($urandom_range(1, 8)));
            prev = p;
        end
        len_q[len_q.size() - 1] += 8;

        for (int i = 0; i < 1024; i++) begin
            exp_v[i] = 1'b0; exp_val[i] = 4'd0; exp_err[i] = 1'b0;
        end
        t = 0;
        last = code_of(15);
        for (int s = 0; s < pat_q.size(); s++) begin
            if (len_q[s] >= STABLE && pat_q[s] != 14'h3FFF && pat_q[s] != last) begin
                logic [4:0] rd;
                rd = ref_dec(pat_q[s]);
                exp_v[t + STABLE + 1]   = 1'b1;
                exp_val[t + STABLE + 1] = rd[3:0];
                exp_err[t + STABLE + 1] = ~rd[4];
                last = pat_q[s];
            end
            for (int k = 0; k < len_q[s]; k++) pat_at[t + k] = pat_q[s];
            t += len_q[s];
        end

        for (int c = 0; c < t; c++) begin
            seg_in = pat_at[c];
            tick();
            check($sformatf("rnd_valid_c%0d", c + 1), 32'(out_valid), 32'(exp_v[c + 1]));
            if (exp_v[c + 1]) begin
                check($sformatf("rnd_value_c%0d", c + 1), 32'(out_value), 32'(exp_val[c + 1]));
                check($sformatf("rnd_err_c%0d", c + 1), 32'(out_err), 32'(exp_err[c + 1]));
            end
        end
        check("rnd_ovr", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
